dcmctrl_spi_master: RTL and testbench
=====================================

# dcmctrl_spi_master

SPI initiator for the dcmctrl register-file protocol. It converts a parallel command (read or write, 7-bit start address, 1–16 byte burst) into one SPI transaction: chip-select low, header byte `{write, addr[6:0]}`, then data bytes, MSB first. The slave auto-increments the address per byte. The block lets an on-chip controller, a test harness or a bridge drive the motor controller's register file from the same fabric.

## Interface
Parameters:
- `CLK_DIV`, default 4: half-period of `spi_clk` in `clk` cycles; legal range 4..255. Below 4 the slave's read-data turnaround fails.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: idle and accepting; a command is taken when `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in 7: start register address.
- `cmd_len` in 4: number of data bytes minus 1.
- `wr_valid` in 1: write byte available.
- `wr_data` in 8: write byte.
- `wr_ready` out 1: one-cycle pulse; `wr_data` consumed this cycle.
- `rd_valid` out 1: one-cycle pulse; `rd_data` holds a received byte.
- `rd_data` out 8: received byte, held until the next `rd_valid`.
- `busy` out 1: transaction in progress (`!cmd_ready`).
- `done` out 1: one-cycle pulse at transaction end.
- `spi_ss` out 1: chip-select, active-low.
- `spi_clk` out 1: serial clock, idles low.
- `spi_mosi` out 1: master-out data.
- `spi_miso` in 1: master-in data.

## Operation
- All outputs are registered.
- Reset values: `spi_ss`=1, `spi_clk`=0, `spi_mosi`=0, `cmd_ready`=0, `rd_valid`/`wr_ready`/`done`=0, `rd_data`=0.
- `cmd_ready` rises on the first `clk` edge after `reset_n` deasserts.
- States:
  - IDLE: `cmd_ready`=1. On accept, latch the command, load header `{cmd_write, cmd_addr}`, go to SETUP.
  - SETUP: `spi_ss`=0, `spi_mosi` = header bit 7, hold `CLK_DIV` cycles, go to HIGH.
  - HIGH: `spi_clk`=1 for `CLK_DIV` cycles. On the last cycle, shift `spi_miso` into the receive register. Go to LOW.
  - LOW: `spi_clk`=0 for `CLK_DIV` cycles. On entry, `spi_mosi` drives the next bit. Go to HIGH, or to STALL or HOLD at a byte boundary.
  - STALL: `spi_clk`=0, `spi_ss`=0, `spi_mosi` held, waiting for `wr_valid`.
  - HOLD: `spi_ss`=0, `spi_clk`=0 for `CLK_DIV` cycles, go to GAP.
  - GAP: `spi_ss`=1 for `CLK_DIV` cycles, then pulse `done` and return to IDLE.
- Byte boundary, i.e. the falling edge after bit 0:
  - Header was just sent, or a data byte with more remaining on a write: `wr_ready` pulses if `wr_valid`=1 and `wr_data` loads into the TX shift register; if `wr_valid`=0, go to STALL. In STALL, the first cycle with `wr_valid`=1 pulses `wr_ready`, loads the byte and restarts a full LOW phase.
  - Read: TX shifts zeros. For every data byte (not the header), `rd_valid` pulses in the cycle `spi_clk` falls after that byte's bit-0 sample.
  - Last data byte done: go to HOLD.
- Header MISO bits are discarded.
- The master does not track the address; the slave wraps 0x7F→0x00.
- Total bits per transaction = 8·(`cmd_len`+2).
- `cmd_valid` while busy is ignored; no queueing.
- `reset_n` low mid-transaction aborts at once: `spi_ss`=1 and `spi_clk`=0 asynchronously. No `done`, `rd_valid` or `wr_ready` fires for the aborted transfer.

## Timing
- H = `CLK_DIV`, N = `cmd_len`+1. Cycle 0 is the accept cycle; no stalls assumed.
- `spi_ss` falls at cycle 1.
- Rising edge k (k = 0..8(N+1)−1) is at cycle 1+H+2Hk; falling edge k is at cycle 1+2H(k+1).
- `spi_ss` rises at cycle 1+H(16(N+1)+1).
- `done` pulses and `cmd_ready` rises at cycle 1+H(16(N+1)+2).
- Each STALL cycle delays every later event by one cycle.
- Minimum `spi_ss` high time between transactions is H+1 cycles.

## Test plan
- Reset: hold `reset_n`=0 → `spi_ss`=1, `spi_clk`=0, `cmd_ready`=0. Release → `cmd_ready`=1 on the next edge.
- Single write, H=4: addr 0x05, `cmd_len`=0, `wr_data`=0xA5 → MOSI bytes 0x85, 0xA5; `done` at cycle 137; a behavioral slave model holds reg[0x05]=0xA5.
- Burst read with wrap: addr 0x7E, `cmd_len`=2, slave regs 0x7E=0x11, 0x7F=0x22, 0x00=0x33 → header 0x7E; three `rd_valid` pulses carrying 0x11, 0x22, 0x33.
- Write stall: `cmd_len`=1, `wr_valid` low for 20 cycles before byte 2 → `spi_clk` low and `spi_ss` low throughout; bytes arrive intact; `done` 20 cycles late.
- Reset mid-burst: assert `reset_n`=0 during data bit 3 → `spi_ss`=1 within the same cycle; no `done` pulse; the next command runs normally.
- Back-to-back: `cmd_valid` held high for two commands → `spi_ss` high for at least H+1 cycles between them; the second header is correct.

Source files
------------

// File: rtl/dcmctrl_spi_master.sv
// SPI initiator for the dcmctrl register file: one command becomes one chip-select
// frame of a header byte {write, addr} followed by 1..16 data bytes, MSB first.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// SETUP | chip-select low, header MSB on MOSI, one half-period before the first rise
// HIGH  | spi_clk high; MISO sampled on the last cycle of the half-period
// LOW   | spi_clk low; next MOSI bit driven on entry
// STALL | write byte boundary with no wr_valid; clock parked low
// HOLD  | chip-select held low for one half-period after the last bit
// GAP   | chip-select high for one half-period, then done
module dcmctrl_spi_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [6:0] cmd_addr,
   input  logic [3:0] cmd_len,
   input  logic       wr_valid,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       spi_ss,
   output logic       spi_clk,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_STALL,
      S_HOLD,
      S_GAP
   } state_t;

   localparam logic [7:0] TMR_LOAD = 8'(CLK_DIV - 1);

   state_t     state, nxt_state;
   logic [7:0] tmr, nxt_tmr;
   logic [2:0] bit_idx, nxt_bit_idx;
   logic [3:0] bytes_left, nxt_bytes_left;
   logic       hdr_phase, nxt_hdr_phase;
   logic       is_write, nxt_is_write;
   logic [7:0] tx_sr, nxt_tx_sr;
   logic [7:0] rx_sr, nxt_rx_sr;
   logic       nxt_cmd_ready, nxt_wr_ready, nxt_rd_valid, nxt_busy, nxt_done;
   logic [7:0] nxt_rd_data;
   logic       nxt_spi_ss, nxt_spi_clk, nxt_spi_mosi;
   logic       tmr_zero;

   assign tmr_zero = (tmr == 8'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         tmr        <= 8'd0;
         bit_idx    <= 3'd7;
         bytes_left <= 4'd0;
         hdr_phase  <= 1'b0;
         is_write   <= 1'b0;
         tx_sr      <= 8'd0;
         rx_sr      <= 8'd0;
         cmd_ready  <= 1'b0;
         wr_ready   <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= 8'd0;
         busy       <= 1'b1;
         done       <= 1'b0;
         spi_ss     <= 1'b1;
         spi_clk    <= 1'b0;
         spi_mosi   <= 1'b0;
      end else begin
         state      <= nxt_state;
         tmr        <= nxt_tmr;
         bit_idx    <= nxt_bit_idx;
         bytes_left <= nxt_bytes_left;
         hdr_phase  <= nxt_hdr_phase;
         is_write   <= nxt_is_write;
         tx_sr      <= nxt_tx_sr;
         rx_sr      <= nxt_rx_sr;
         cmd_ready  <= nxt_cmd_ready;
         wr_ready   <= nxt_wr_ready;
         rd_valid   <= nxt_rd_valid;
         rd_data    <= nxt_rd_data;
         busy       <= nxt_busy;
         done       <= nxt_done;
         spi_ss     <= nxt_spi_ss;
         spi_clk    <= nxt_spi_clk;
         spi_mosi   <= nxt_spi_mosi;
      end
   end

   // Outputs are computed from the next state so every pin comes straight off a flop.
   // wr_ready is therefore high in the cycle after wr_data was captured, which still
   // reads as a plain valid/ready handshake to the producer.
   always_comb begin
      nxt_state      = state;
      nxt_tmr        = tmr_zero ? 8'd0 : tmr - 8'd1;
      nxt_bit_idx    = bit_idx;
      nxt_bytes_left = bytes_left;
      nxt_hdr_phase  = hdr_phase;
      nxt_is_write   = is_write;
      nxt_tx_sr      = tx_sr;
      nxt_rx_sr      = rx_sr;
      nxt_spi_mosi   = spi_mosi;
      nxt_rd_data    = rd_data;
      nxt_wr_ready   = 1'b0;
      nxt_rd_valid   = 1'b0;
      nxt_done       = 1'b0;

      case (state)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               nxt_state      = S_SETUP;
               nxt_tmr        = TMR_LOAD;
               nxt_is_write   = cmd_write;
               nxt_tx_sr      = {cmd_write, cmd_addr};
               nxt_spi_mosi   = cmd_write;
               nxt_bit_idx    = 3'd7;
               nxt_bytes_left = cmd_len;
               nxt_hdr_phase  = 1'b1;
            end
         end
         S_SETUP: begin
            if (tmr_zero) begin
               nxt_state = S_HIGH;
               nxt_tmr   = TMR_LOAD;
            end
         end
         S_HIGH: begin
            if (tmr_zero) begin
               nxt_rx_sr = {rx_sr[6:0], spi_miso};
               nxt_tmr   = TMR_LOAD;
               if (bit_idx != 3'd0) begin
                  nxt_state    = S_LOW;
                  nxt_bit_idx  = bit_idx - 3'd1;
                  nxt_tx_sr    = {tx_sr[6:0], 1'b0};
                  nxt_spi_mosi = tx_sr[6];
               end else begin
                  if (!hdr_phase && !is_write) begin
                     nxt_rd_valid = 1'b1;
                     nxt_rd_data  = {rx_sr[6:0], spi_miso};
                  end
                  if (!hdr_phase && bytes_left == 4'd0) begin
                     nxt_state = S_HOLD;
                  end else begin
                     nxt_bit_idx   = 3'd7;
                     nxt_hdr_phase = 1'b0;
                     if (!hdr_phase)
                        nxt_bytes_left = bytes_left - 4'd1;
                     if (is_write) begin
                        if (wr_valid) begin
                           nxt_state    = S_LOW;
                           nxt_wr_ready = 1'b1;
                           nxt_tx_sr    = wr_data;
                           nxt_spi_mosi = wr_data[7];
                        end else begin
                           nxt_state = S_STALL;
                        end
                     end else begin
                        nxt_state    = S_LOW;
                        nxt_tx_sr    = 8'd0;
                        nxt_spi_mosi = 1'b0;
                     end
                  end
               end
            end
         end
         S_LOW: begin
            if (tmr_zero) begin
               nxt_state = S_HIGH;
               nxt_tmr   = TMR_LOAD;
            end
         end
         S_STALL: begin
            if (wr_valid) begin
               nxt_state    = S_LOW;
               nxt_tmr      = TMR_LOAD;
               nxt_wr_ready = 1'b1;
               nxt_tx_sr    = wr_data;
               nxt_spi_mosi = wr_data[7];
            end
         end
         S_HOLD: begin
            if (tmr_zero) begin
               nxt_state = S_GAP;
               nxt_tmr   = TMR_LOAD;
            end
         end
         S_GAP: begin
            if (tmr_zero) begin
               nxt_state = S_IDLE;
               nxt_done  = 1'b1;
            end
         end
         default: nxt_state = S_IDLE;
      endcase

      nxt_spi_clk   = (nxt_state == S_HIGH);
      nxt_spi_ss    = (nxt_state == S_IDLE) || (nxt_state == S_GAP);
      nxt_cmd_ready = (nxt_state == S_IDLE);
      nxt_busy      = !nxt_cmd_ready;
   end

endmodule

// File: tb/tb_dcmctrl_spi_master.sv
// Bench for dcmctrl_spi_master: behavioral register-file slave plus MOSI/read-data
// scoreboards, with one task per scenario.
module tb_dcmctrl_spi_master;

   localparam int H = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic [6:0] cmd_addr = 7'd0;
   logic [3:0] cmd_len = 4'd0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'd0;
   logic       wr_ready;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       busy;
   logic       done;
   logic       spi_ss;
   logic       spi_clk;
   logic       spi_mosi;
   logic       spi_miso = 1'b0;

   dcmctrl_spi_master #(.CLK_DIV(H)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
      .spi_ss(spi_ss), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [7:0] regs [128];
   logic [7:0] exp_mosi [$];
   logic [7:0] exp_rd [$];
   logic [7:0] wr_q [$];
   int wr_sent = 0;
   int stall_idx = -1;
   int stall_until = 0;
   int done_cnt = 0, rdv_cnt = 0, wrr_cnt = 0;
   int last_gap = 0, ss_run = 0;

   int         s_bits = 0;
   logic [7:0] s_sh = 8'd0, s_tx = 8'd0, e_mon;
   logic       s_wr = 1'b0;
   logic [6:0] s_addr = 7'd0;
   logic       prev_clk = 1'b0, prev_ss = 1'b1;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Write-data producer: advances on wr_ready, optionally withholds one byte.
   initial forever begin
      @(negedge clk);
      if (wr_ready && wr_q.size() > 0) begin
         void'(wr_q.pop_front());
         wr_sent++;
      end
      if (wr_q.size() > 0 && !(wr_sent == stall_idx && cyc < stall_until)) begin
         wr_valid = 1'b1;
         wr_data  = wr_q[0];
      end else begin
         wr_valid = 1'b0;
         wr_data  = 8'd0;
      end
   end

   // Slave model and scoreboard checker.
   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         s_bits = 0; prev_clk = 1'b0; prev_ss = 1'b1; spi_miso = 1'b0; ss_run = 0;
      end else begin
         if (done) done_cnt++;
         if (wr_ready) wrr_cnt++;
         if (rd_valid) begin
            rdv_cnt++;
            checks++;
            if (exp_rd.size() == 0) begin
               errors++;
               $display("FAIL rd_data: got %h with no byte expected", rd_data);
            end else begin
               e_mon = exp_rd.pop_front();
               if (rd_data !== e_mon) begin
                  errors++;
                  $display("FAIL rd_data: got %h expected %h", rd_data, e_mon);
               end
            end
            checks++;
            if (!(prev_clk && !spi_clk)) begin
               errors++;
               $display("FAIL rd_valid_timing: spi_clk %b->%b expected 1->0", prev_clk, spi_clk);
            end
         end
         if (spi_ss) begin
            s_bits = 0;
            ss_run++;
            spi_miso = 1'b0;
         end else begin
            if (prev_ss) last_gap = ss_run;
            ss_run = 0;
            if (spi_clk && !prev_clk) begin
               s_sh = {s_sh[6:0], spi_mosi};
               s_bits++;
               if (s_bits % 8 == 0) begin
                  checks++;
                  if (exp_mosi.size() == 0) begin
                     errors++;
                     $display("FAIL mosi_byte: got %h with no byte expected", s_sh);
                  end else begin
                     e_mon = exp_mosi.pop_front();
                     if (s_sh !== e_mon) begin
                        errors++;
                        $display("FAIL mosi_byte: got %h expected %h", s_sh, e_mon);
                     end
                  end
                  if (s_bits == 8) begin
                     s_wr = s_sh[7];
                     s_addr = s_sh[6:0];
                  end else if (s_wr) begin
                     regs[s_addr] = s_sh;
                     s_addr = s_addr + 7'd1;
                  end
               end
            end else if (!spi_clk && prev_clk) begin
               if (!s_wr && s_bits >= 8) begin
                  if (s_bits % 8 == 0) begin
                     s_tx = regs[s_addr];
                     s_addr = s_addr + 7'd1;
                  end
                  spi_miso = s_tx[7];
                  s_tx = {s_tx[6:0], 1'b0};
               end
            end
         end
         prev_clk = spi_clk;
         prev_ss  = spi_ss;
      end
   end

   task automatic issue(input logic w, input logic [6:0] a, input logic [3:0] l, output int acc);
      int n = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_timeout: cmd_ready=%b expected 1", cmd_ready);
      end
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
      acc = cyc + 1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int acc, input int exp_cyc, input string name);
      int n = 0;
      while (done !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done_timeout: done=%b expected 1", name, done);
      end else if (cyc - acc + 1 != exp_cyc) begin
         errors++;
         $display("FAIL %s_done_cycle: got %0d expected %0d", name, cyc - acc + 1, exp_cyc);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready_at_done: got %b expected 1", name, cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL %s_done_pulse: got %b expected 0", name, done);
      end
      checks++;
      if (exp_mosi.size() != 0 || exp_rd.size() != 0) begin
         errors++;
         $display("FAIL %s_leftover: mosi %0d rd %0d expected 0 0", name, exp_mosi.size(), exp_rd.size());
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 128; i++) regs[i] = 8'd0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({spi_ss, spi_clk, spi_mosi, cmd_ready, done, rd_valid, wr_ready} !== 7'b1000000 || rd_data !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: ss clk mosi rdy done rdv wrr=%b rd_data=%h expected 1000000 00",
                  {spi_ss, spi_clk, spi_mosi, cmd_ready, done, rd_valid, wr_ready}, rd_data);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: cmd_ready=%b busy=%b expected 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_single_write();
      int acc;
      wr_sent = 0; stall_idx = -1;
      wr_q.push_back(8'hA5);
      exp_mosi.push_back(8'h85);
      exp_mosi.push_back(8'hA5);
      issue(1'b1, 7'h05, 4'd0, acc);
      wait_done(acc, 137, "single_write");
      checks++;
      if (regs[7'h05] !== 8'hA5) begin
         errors++;
         $display("FAIL single_write_reg: got %h expected a5", regs[7'h05]);
      end
   endtask

   task automatic test_burst_read_wrap();
      int acc;
      int rd0;
      regs[7'h7E] = 8'h11; regs[7'h7F] = 8'h22; regs[7'h00] = 8'h33;
      exp_mosi.push_back(8'h7E);
      repeat (3) exp_mosi.push_back(8'h00);
      exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
      rd0 = rdv_cnt;
      issue(1'b0, 7'h7E, 4'd2, acc);
      wait_done(acc, 1 + H * (16 * 4 + 2), "burst_read");
      checks++;
      if (rdv_cnt - rd0 != 3) begin
         errors++;
         $display("FAIL burst_read_count: got %0d expected 3", rdv_cnt - rd0);
      end
   endtask

   task automatic test_write_stall();
      int acc, n, r;
      int stall_bad = 0;
      wr_sent = 0; stall_idx = 1;
      wr_q.push_back(8'hC3); wr_q.push_back(8'h3C);
      exp_mosi.push_back(8'hC0); exp_mosi.push_back(8'hC3); exp_mosi.push_back(8'h3C);
      issue(1'b1, 7'h40, 4'd1, acc);
      stall_until = acc + 147;
      n = 0;
      while (done !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
         r = cyc - acc + 1;
         if (r >= 129 && r <= 148 && (spi_clk !== 1'b0 || spi_ss !== 1'b0)) stall_bad++;
      end
      wait_done(acc, 1 + H * (16 * 3 + 2) + 20, "write_stall");
      stall_idx = -1;
      checks++;
      if (stall_bad != 0) begin
         errors++;
         $display("FAIL stall_lines: got %0d bad cycles expected 0", stall_bad);
      end
      checks++;
      if (regs[7'h40] !== 8'hC3 || regs[7'h41] !== 8'h3C) begin
         errors++;
         $display("FAIL stall_regs: got %h %h expected c3 3c", regs[7'h40], regs[7'h41]);
      end
   endtask

   task automatic test_reset_mid_burst();
      int acc, n, d0, r0, w0;
      wr_sent = 0; stall_idx = -1;
      regs[7'h10] = 8'h00;
      wr_q.push_back(8'hAA); wr_q.push_back(8'hBB);
      exp_mosi.push_back(8'h90); exp_mosi.push_back(8'hAA); exp_mosi.push_back(8'hBB);
      issue(1'b1, 7'h10, 4'd1, acc);
      n = 0;
      while (cyc - acc + 1 < 103 && n < 500) begin
         @(negedge clk);
         n++;
      end
      d0 = done_cnt; r0 = rdv_cnt; w0 = wrr_cnt;
      reset_n = 1'b0;
      #1;
      checks++;
      if (spi_ss !== 1'b1 || spi_clk !== 1'b0) begin
         errors++;
         $display("FAIL abort_lines: ss=%b clk=%b expected 1 0", spi_ss, spi_clk);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_ready: got %b expected 0", cmd_ready);
      end
      exp_mosi.delete();
      wr_q.delete();
      wr_sent = 0;
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (done_cnt != d0 || rdv_cnt != r0 || wrr_cnt != w0) begin
         errors++;
         $display("FAIL abort_pulses: done/rdv/wrr deltas %0d %0d %0d expected 0 0 0",
                  done_cnt - d0, rdv_cnt - r0, wrr_cnt - w0);
      end
      checks++;
      if (regs[7'h10] !== 8'h00) begin
         errors++;
         $display("FAIL abort_reg: got %h expected 00", regs[7'h10]);
      end
      wr_q.push_back(8'h5A);
      exp_mosi.push_back(8'hA0); exp_mosi.push_back(8'h5A);
      issue(1'b1, 7'h20, 4'd0, acc);
      wait_done(acc, 137, "after_abort");
      checks++;
      if (regs[7'h20] !== 8'h5A) begin
         errors++;
         $display("FAIL after_abort_reg: got %h expected 5a", regs[7'h20]);
      end
   endtask

   task automatic test_back_to_back();
      int acc1, acc2, n;
      wr_sent = 0; stall_idx = -1;
      exp_mosi.push_back(8'h05); exp_mosi.push_back(8'h00);
      exp_rd.push_back(8'hA5);
      exp_mosi.push_back(8'hB0); exp_mosi.push_back(8'h3C);
      wr_q.push_back(8'h3C);
      n = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h05; cmd_len = 4'd0;
      acc1 = cyc + 1;
      @(negedge clk);
      cmd_write = 1'b1; cmd_addr = 7'h30; cmd_len = 4'd0;
      n = 0;
      while (done !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      acc2 = cyc + 1;
      checks++;
      if (done !== 1'b1 || cyc - acc1 + 1 != 137) begin
         errors++;
         $display("FAIL b2b_first_done: done=%b at %0d expected 1 at 137", done, cyc - acc1 + 1);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_accept: busy=%b expected 1", busy);
      end
      wait_done(acc2, 137, "b2b_second");
      checks++;
      if (last_gap < H + 1) begin
         errors++;
         $display("FAIL b2b_ss_gap: got %0d expected >= %0d", last_gap, H + 1);
      end
      checks++;
      if (regs[7'h30] !== 8'h3C) begin
         errors++;
         $display("FAIL b2b_reg: got %h expected 3c", regs[7'h30]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_write();
      test_burst_read_wrap();
      test_write_stall();
      test_reset_mid_burst();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
